mips_mem_arbiter: RTL
=====================

# mips_mem_arbiter

Single-clock arbiter that shares the pipe_MIPS32 unified word memory among three requesters: instruction fetch (IF), the MEM-stage load/store port (DM) and a debug/loader port (DBG) used by benches to preload programs and inspect results. It issues at most one memory access per cycle. It routes synchronous-read data back to the requester that issued the read. It bounds IF starvation behind back-to-back loads and stores.

## Interface
- AW, 10, word-address width (memory depth 2^AW words)
- DW, 32, data width
- STARVE_MAX, 4, consecutive lost IF arbitration cycles before IF is forced to win (1..15)

- clk1  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- halted  in  1  CPU HALTED flag; while 1, IF requests are ignored
- if_req  in  1  IF read request, held until granted
- if_addr  in  AW  IF word address
- if_gnt  out  1  IF access issued this cycle
- if_rvalid  out  1  IF read data valid
- if_rdata  out  DW  IF read data
- dm_req, dm_we  in  1 each  DM request and write enable
- dm_addr  in  AW; dm_wdata  in  DW
- dm_gnt, dm_rvalid  out  1 each; dm_rdata  out  DW
- dbg_req, dbg_we  in  1 each; dbg_addr  in  AW; dbg_wdata  in  DW
- dbg_gnt, dbg_rvalid  out  1 each; dbg_rdata  out  DW
- mem_en, mem_we  out  1 each  memory strobe and write enable
- mem_addr  out  AW; mem_wdata  out  DW
- mem_rdata  in  DW  memory read data, registered by memory, valid the cycle after mem_en && !mem_we

## Operation
- Grant is combinational from the current requests and registered state. Exactly zero or one gnt is high per cycle. mem_en equals the OR of all gnts. mem_we, mem_addr and mem_wdata are muxed from the granted requester. When no requester is granted, mem_addr and mem_wdata are 0.
- Priority: DBG > (DM vs IF). Between DM and IF, DM wins unless starve_cnt == STARVE_MAX, in which case IF wins.
- IF is eligible only when if_req && !halted. The IF port has no write enable; IF accesses are always reads.
- starve_cnt (4 bits):
  - Cleared when if_gnt, when !if_req, or when halted.
  - Otherwise increments, saturating at STARVE_MAX, when IF is eligible but not granted, including cycles lost to DBG.
- rd_owner register: values NONE, IF, DM or DBG.
  - Loaded each cycle with the owner of a granted read.
  - Loaded with NONE on a write or on no grant.
- Read return: in the cycle after a read grant, the <port>_rvalid selected by rd_owner is 1 and <port>_rdata = mem_rdata. Other rdata outputs hold 0.
- Writes produce no rvalid.
- A write followed by a read to the same address in the next cycle returns the new data; the memory is write-first across cycles.
- A requester must hold req, addr, we and wdata stable until gnt. It may drop req or change the request in the cycle after gnt.

## Timing
- Reset values: starve_cnt = 0, rd_owner = NONE.
- While rst = 1, all gnt outputs and mem_en are forced to 0. All rvalid outputs are 0 in the cycle after any cycle with rst = 1. All rdata outputs are 0.
- Read latency: gnt in cycle N, rvalid and rdata in cycle N+1. Throughput is 1 access per cycle, back-to-back reads pipelined.
- rst asserted in cycle N+1 after a read grant in cycle N: rvalid stays 0 and the read is lost.
- halted rising while IF is waiting: IF loses eligibility the same cycle. starve_cnt clears on the next edge.
- Simultaneous DBG, DM and IF requests: DBG is granted. starve_cnt still increments.
- Worst-case IF wait with DBG idle is STARVE_MAX cycles. With DBG continuously requesting, IF wait is unbounded by design (debug has absolute priority).

## Test plan
- Reset: rst = 1 for 2 cycles with all reqs = 1 -> all gnt, rvalid and mem_en = 0 throughout and in the cycle after; rd_owner = NONE.
- IF read: mem[0] = 32'h28010078, if_req with if_addr = 0 in cycle N -> if_gnt = 1 in N; if_rvalid = 1 and if_rdata = 32'h28010078 in N+1; dm_rvalid and dbg_rvalid = 0.
- Starvation: STARVE_MAX = 4, if_req and dm_req (read) held continuously -> dm_gnt in cycles 1-4, if_gnt in cycle 5, dm_gnt in cycles 6-9, if_gnt in cycle 10. No cycle has two gnts.
- DBG priority and write-first: dbg write addr 120 data 85 and dm read addr 120 in cycle N -> dbg_gnt in N with mem_we = 1; dm_gnt in N+1; dm_rvalid in N+2 with dm_rdata = 85.
- Halt: halted = 1, if_req = 1 and dm_req alternating -> if_gnt never 1; starve_cnt stays 0; dm served every request. After halted drops, IF is granted on the first cycle DM is idle.
- Reset mid-read: dm read granted in cycle N, rst = 1 in N+1 -> dm_rvalid = 0 in N+1 and N+2. After rst drops, a new dm read returns correct data one cycle after its grant.

Source files
------------

// File: rtl/mips_mem_arbiter_if.sv
// Request/grant/return bundle between the three memory requesters, the arbiter and the word memory.
// master = requesters plus memory side, slave = arbiter.
interface mips_mem_arbiter_if #(
  parameter int AW = 10,
  parameter int DW = 32
);
  logic          halted;

  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;

  logic          dm_req;
  logic          dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic          dm_gnt;
  logic          dm_rvalid;
  logic [DW-1:0] dm_rdata;

  logic          dbg_req;
  logic          dbg_we;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_wdata;
  logic          dbg_gnt;
  logic          dbg_rvalid;
  logic [DW-1:0] dbg_rdata;

  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  modport master (
    output halted,
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_gnt, dm_rvalid, dm_rdata,
    output dbg_req, dbg_we, dbg_addr, dbg_wdata,
    input  dbg_gnt, dbg_rvalid, dbg_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  modport slave (
    input  halted,
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_gnt, dm_rvalid, dm_rdata,
    input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
    output dbg_gnt, dbg_rvalid, dbg_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mips_mem_arbiter.sv
// One-access-per-cycle arbiter (DBG > DM > IF, IF forced after STARVE_MAX losses) for a sync-read word memory.
// Grant is combinational; read data returns one cycle after grant to the issuing port; losers hold their request.
module mips_mem_arbiter #(
  parameter int AW         = 10,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                  clk1,
  input  logic                  rst,
  mips_mem_arbiter_if.slave     bus
);
  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_DM   = 2'd2;
  localparam logic [1:0] OWN_DBG  = 2'd3;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]    starve_cnt_q, starve_cnt_d;
  logic [1:0]    rd_owner_q, rd_owner_d;
  logic          if_elig;
  logic          if_gnt, dm_gnt, dbg_gnt;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          if_rvalid, dm_rvalid, dbg_rvalid;

  assign if_elig = bus.if_req && !bus.halted;

  always_comb begin
    if_gnt  = 1'b0;
    dm_gnt  = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst) begin
      if (bus.dbg_req) begin
        dbg_gnt = 1'b1;
      end else if (bus.dm_req && if_elig) begin
        // DM normally wins, but IF takes the slot once it has lost STARVE_MAX times in a row
        if (starve_cnt_q == STARVE_LIM) if_gnt = 1'b1;
        else                            dm_gnt = 1'b1;
      end else if (bus.dm_req) begin
        dm_gnt = 1'b1;
      end else if (if_elig) begin
        if_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (dbg_gnt) begin
      mem_we    = bus.dbg_we;
      mem_addr  = bus.dbg_addr;
      mem_wdata = bus.dbg_wdata;
    end else if (dm_gnt) begin
      mem_we    = bus.dm_we;
      mem_addr  = bus.dm_addr;
      mem_wdata = bus.dm_wdata;
    end else if (if_gnt) begin
      mem_addr  = bus.if_addr;
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !bus.if_req || bus.halted) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q < STARVE_LIM) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    rd_owner_d = OWN_NONE;
    if (dbg_gnt && !bus.dbg_we)     rd_owner_d = OWN_DBG;
    else if (dm_gnt && !bus.dm_we)  rd_owner_d = OWN_DM;
    else if (if_gnt)                rd_owner_d = OWN_IF;
  end

  always_ff @(posedge clk1) begin
    if (rst) begin
      starve_cnt_q <= 4'd0;
      rd_owner_q   <= OWN_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // A read whose return cycle coincides with reset is dropped
  assign if_rvalid  = !rst && (rd_owner_q == OWN_IF);
  assign dm_rvalid  = !rst && (rd_owner_q == OWN_DM);
  assign dbg_rvalid = !rst && (rd_owner_q == OWN_DBG);

  assign bus.if_gnt     = if_gnt;
  assign bus.dm_gnt     = dm_gnt;
  assign bus.dbg_gnt    = dbg_gnt;
  assign bus.mem_en     = if_gnt | dm_gnt | dbg_gnt;
  assign bus.mem_we     = mem_we;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

  assign bus.if_rvalid  = if_rvalid;
  assign bus.dm_rvalid  = dm_rvalid;
  assign bus.dbg_rvalid = dbg_rvalid;
  assign bus.if_rdata   = if_rvalid  ? bus.mem_rdata : '0;
  assign bus.dm_rdata   = dm_rvalid  ? bus.mem_rdata : '0;
  assign bus.dbg_rdata  = dbg_rvalid ? bus.mem_rdata : '0;
endmodule
